// File: rtl/ysyx_22051013_axi_master_bridge.sv
// ysyx_22051013_axi_master_bridge
//   Merges IFU instruction fetches and LSU loads/stores onto one single-beat
//   AXI master port (64-bit data, no bursts) and routes each response back
//   to whoever issued the request.
//
//   The read channel and the write channel each run their own small FSM, so
//   an IFU fetch can be in flight while an LSU store is in flight.
//   An LSU load is not started while a store is pending or in flight, or in
//   the cycle that store's completion pulse is being delivered.
//   Because of this, a load never overtakes an earlier store.
//
// Ports
//   clk, rst                         clock; synchronous active-high reset
//   ifu_rd_*   / ifu_resp_*          IFU read request / 1-cycle response pulse
//   lsu_rd_*   / lsu_resp_*          LSU read request / 1-cycle response pulse
//   lsu_wr_*   / lsu_wr_done         LSU write request / 1-cycle completion pulse
//   axi_aw_* axi_w_* axi_b_*         AXI write address / data / response
//   axi_ar_* axi_r_*                 AXI read address / data
module ysyx_22051013_axi_master_bridge #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // IFU read port
    input  logic              ifu_rd_valid,
    input  logic [ADDR_W-1:0] ifu_rd_addr,
    output logic              ifu_rd_ready,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,
    // LSU read port
    input  logic              lsu_rd_valid,
    input  logic [ADDR_W-1:0] lsu_rd_addr,
    output logic              lsu_rd_ready,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,
    // LSU write port
    input  logic              lsu_wr_valid,
    input  logic [ADDR_W-1:0] lsu_wr_addr,
    input  logic [DATA_W-1:0] lsu_wr_data,
    input  logic [STRB_W-1:0] lsu_wr_strb,
    output logic              lsu_wr_ready,
    output logic              lsu_wr_done,
    // AXI write address
    output logic [ID_W-1:0]   axi_aw_id,
    output logic [ADDR_W-1:0] axi_aw_addr,
    output logic              axi_aw_valid,
    input  logic              axi_aw_ready,
    // AXI write data
    output logic [DATA_W-1:0] axi_w_data,
    output logic [STRB_W-1:0] axi_w_strb,
    output logic              axi_w_valid,
    input  logic              axi_w_ready,
    // AXI write response
    input  logic [ID_W-1:0]   axi_b_id,
    input  logic [1:0]        axi_b_resp,
    input  logic              axi_b_valid,
    output logic              axi_b_ready,
    // AXI read address
    output logic [ID_W-1:0]   axi_ar_id,
    output logic [ADDR_W-1:0] axi_ar_addr,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,
    // AXI read data
    input  logic [ID_W-1:0]   axi_r_id,
    input  logic [DATA_W-1:0] axi_r_data,
    input  logic [1:0]        axi_r_resp,
    input  logic              axi_r_valid,
    output logic              axi_r_ready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

    localparam logic [ID_W-1:0] IFU_ID = ID_W'(0);
    localparam logic [ID_W-1:0] LSU_ID = ID_W'(1);

    r_state_t r_state_reg, r_state_next;
    w_state_t w_state_reg, w_state_next;

    logic [ADDR_W-1:0] ar_addr_reg;
    logic [ID_W-1:0]   ar_id_reg;
    logic              rd_owner_lsu_reg;
    logic              ifu_resp_valid_reg, lsu_resp_valid_reg;
    logic [DATA_W-1:0] ifu_resp_data_reg, lsu_resp_data_reg;

    logic [ADDR_W-1:0] aw_addr_reg;
    logic [ID_W-1:0]   aw_id_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic [STRB_W-1:0] w_strb_reg;
    logic              aw_done_reg, w_done_reg, wr_done_reg;

    logic lsu_rd_grant, ifu_rd_grant, wr_accept;
    logic aw_hs, w_hs;

    // Response IDs and codes are not used: with a single outstanding
    // transaction per channel the owner register already knows the target.
    logic unused_inputs;
    assign unused_inputs = ^{axi_r_id, axi_r_resp, axi_b_id, axi_b_resp};

    // A store always wins a same-cycle tie against an LSU load. This term
    // depends only on the write side, so there is no combinational loop.
    assign wr_accept = !rst && (w_state_reg == W_IDLE) && lsu_wr_valid;

    assign aw_hs = axi_aw_valid && axi_aw_ready;
    assign w_hs  = axi_w_valid && axi_w_ready;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state_reg <= R_IDLE;
        else     r_state_reg <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state_reg;
        lsu_rd_grant = 1'b0;
        ifu_rd_grant = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (!rst) begin
                    // The load waits for the store to be idle and its done
                    // pulse to be delivered, so read-after-write is safe.
                    if (lsu_rd_valid && (w_state_reg == W_IDLE) && !wr_accept && !wr_done_reg)
                        lsu_rd_grant = 1'b1;
                    else if (ifu_rd_valid)
                        ifu_rd_grant = 1'b1;
                end
                if (lsu_rd_grant || ifu_rd_grant) r_state_next = R_AR;
            end
            R_AR:    if (axi_ar_ready) r_state_next = R_WAIT;
            R_WAIT:  if (axi_r_valid)  r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_addr_reg        <= '0;
            ar_id_reg          <= '0;
            rd_owner_lsu_reg   <= 1'b0;
            ifu_resp_valid_reg <= 1'b0;
            lsu_resp_valid_reg <= 1'b0;
            ifu_resp_data_reg  <= '0;
            lsu_resp_data_reg  <= '0;
        end else begin
            ifu_resp_valid_reg <= 1'b0;
            lsu_resp_valid_reg <= 1'b0;
            if (lsu_rd_grant) begin
                ar_addr_reg      <= lsu_rd_addr;
                ar_id_reg        <= LSU_ID;
                rd_owner_lsu_reg <= 1'b1;
            end else if (ifu_rd_grant) begin
                ar_addr_reg      <= ifu_rd_addr;
                ar_id_reg        <= IFU_ID;
                rd_owner_lsu_reg <= 1'b0;
            end
            if ((r_state_reg == R_WAIT) && axi_r_valid) begin
                if (rd_owner_lsu_reg) begin
                    lsu_resp_data_reg  <= axi_r_data;
                    lsu_resp_valid_reg <= 1'b1;
                end else begin
                    ifu_resp_data_reg  <= axi_r_data;
                    ifu_resp_valid_reg <= 1'b1;
                end
            end
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) w_state_reg <= W_IDLE;
        else     w_state_reg <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE: if (wr_accept) w_state_next = W_REQ;
            // AW and W may complete in either order or together.
            W_REQ:  if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) w_state_next = W_RESP;
            W_RESP: if (axi_b_valid) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_addr_reg <= '0;
            aw_id_reg   <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wr_done_reg <= 1'b0;
        end else begin
            wr_done_reg <= (w_state_reg == W_RESP) && axi_b_valid;
            if (wr_accept) begin
                aw_addr_reg <= lsu_wr_addr;
                aw_id_reg   <= LSU_ID;
                w_data_reg  <= lsu_wr_data;
                w_strb_reg  <= lsu_wr_strb;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign ifu_rd_ready   = ifu_rd_grant;
    assign lsu_rd_ready   = lsu_rd_grant;
    assign ifu_resp_valid = ifu_resp_valid_reg;
    assign ifu_resp_data  = ifu_resp_data_reg;
    assign lsu_resp_valid = lsu_resp_valid_reg;
    assign lsu_resp_data  = lsu_resp_data_reg;
    assign lsu_wr_ready   = wr_accept;
    assign lsu_wr_done    = wr_done_reg;

    assign axi_ar_id    = ar_id_reg;
    assign axi_ar_addr  = ar_addr_reg;
    assign axi_ar_valid = (r_state_reg == R_AR);
    assign axi_r_ready  = (r_state_reg == R_WAIT);

    // Each valid drops once its own handshake is done, to avoid a second transfer.
    assign axi_aw_id    = aw_id_reg;
    assign axi_aw_addr  = aw_addr_reg;
    assign axi_aw_valid = (w_state_reg == W_REQ) && !aw_done_reg;
    assign axi_w_data   = w_data_reg;
    assign axi_w_strb   = w_strb_reg;
    assign axi_w_valid  = (w_state_reg == W_REQ) && !w_done_reg;
    assign axi_b_ready  = (w_state_reg == W_RESP);

endmodule
